liteeth_sram_fifo: RTL and testbench

LITEETH_SRAM_FIFO -- requirements
Module: liteeth_sram_fifo

---
 rtl/liteeth_sram_fifo_pkg.sv | 13 +
 rtl/liteeth_sram_fifo_if.sv | 23 ++
 rtl/liteeth_sram_fifo_obuf.sv | 50 +++++
 rtl/liteeth_sram_fifo.sv | 79 +++++++
 tb/tb_liteeth_sram_fifo.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/liteeth_sram_fifo_pkg.sv
// Shared sizing for the SRAM-backed stream FIFO: payload width, macro geometry,
// the derived pointer width and the output-buffer occupancy type.
package liteeth_sram_fifo_pkg;

  localparam int unsigned BITS       = 12;
  localparam int unsigned WORD_DEPTH = 128;
  localparam int unsigned ADDR_WIDTH = 7;
  localparam int unsigned PTR_WIDTH  = ADDR_WIDTH + 1;
  localparam int unsigned OBUF_DEPTH = 2;

  typedef logic [1:0] obuf_count_t;

endpackage

// File: rtl/liteeth_sram_fifo_if.sv
// Write/read stream bundle of the FIFO plus its occupancy; slave is the FIFO side.
interface liteeth_sram_fifo_if #(
  parameter int unsigned BITS       = liteeth_sram_fifo_pkg::BITS,
  parameter int unsigned ADDR_WIDTH = liteeth_sram_fifo_pkg::ADDR_WIDTH
);
  logic                  sink_valid;
  logic                  sink_ready;
  logic [BITS-1:0]       sink_data;
  logic                  source_valid;
  logic                  source_ready;
  logic [BITS-1:0]       source_data;
  logic [ADDR_WIDTH:0]   level;

  modport master (
    output sink_valid, sink_data, source_ready,
    input  sink_ready, source_valid, source_data, level
  );

  modport slave (
    input  sink_valid, sink_data, source_ready,
    output sink_ready, source_valid, source_data, level
  );
endinterface

// File: rtl/liteeth_sram_fifo_obuf.sv
// Two-entry output buffer absorbing SRAM read latency; entry 0 is always the oldest.
module liteeth_sram_fifo_obuf #(
  parameter int unsigned BITS = liteeth_sram_fifo_pkg::BITS
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_push,
  input  logic [BITS-1:0] i_data,
  input  logic            i_pop,
  output logic [BITS-1:0] o_data,
  output logic            o_valid,
  output logic [1:0]      o_count
);
  import liteeth_sram_fifo_pkg::*;

  logic [BITS-1:0] r_mem [OBUF_DEPTH];
  obuf_count_t     r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_push && !i_pop) begin
      r_count <= r_count + 2'd1;
    end else if (i_pop && !i_push) begin
      r_count <= r_count - 2'd1;
    end
  end

  // Push+pop with one entry held replaces it in place; with two, shift then append.
  always_ff @(posedge i_clk) begin
    unique case ({i_push, i_pop})
      2'b10: r_mem[r_count[0]] <= i_data;
      2'b01: r_mem[0] <= r_mem[1];
      2'b11: begin
        if (r_count == 2'd1) begin
          r_mem[0] <= i_data;
        end else begin
          r_mem[0] <= r_mem[1];
          r_mem[1] <= i_data;
        end
      end
      default: ;
    endcase
  end

  assign o_data  = r_mem[0];
  assign o_valid = (r_count != '0);
  assign o_count = r_count;

endmodule

// File: rtl/liteeth_sram_fifo.sv
// Stream FIFO over an external 1rw1r SRAM macro: rw0 takes writes, r0 feeds a
// two-entry output buffer so a one-cycle read latency still sustains full rate.
module liteeth_sram_fifo #(
  parameter int unsigned BITS       = liteeth_sram_fifo_pkg::BITS,
  parameter int unsigned WORD_DEPTH = liteeth_sram_fifo_pkg::WORD_DEPTH,
  parameter int unsigned ADDR_WIDTH = liteeth_sram_fifo_pkg::ADDR_WIDTH
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  liteeth_sram_fifo_if.slave    stream,
  output logic                  mem_rw0_ce,
  output logic                  mem_rw0_we,
  output logic [ADDR_WIDTH-1:0] mem_rw0_addr,
  output logic [BITS-1:0]       mem_rw0_wd,
  output logic                  mem_r0_ce,
  output logic [ADDR_WIDTH-1:0] mem_r0_addr,
  input  logic [BITS-1:0]       mem_r0_rd
);
  import liteeth_sram_fifo_pkg::*;

  localparam int unsigned PW = ADDR_WIDTH + 1;

  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic            r_inflight;
  logic [PW-1:0]   w_sram_count;
  logic            w_push;
  logic            w_pop;
  logic            w_issue;
  logic [2:0]      w_ob_proj;
  logic            w_ob_valid;
  logic [1:0]      w_ob_count;
  logic [BITS-1:0] w_ob_data;

  assign w_sram_count      = r_wr_ptr - r_rd_ptr;
  assign stream.sink_ready = !sys_rst && (w_sram_count < PW'(WORD_DEPTH));
  assign w_push            = stream.sink_valid && stream.sink_ready;
  assign w_pop             = w_ob_valid && stream.source_ready;

  // Buffer occupancy after this edge if nothing new is issued; a read is only
  // launched when its data is guaranteed a free slot one cycle later.
  assign w_ob_proj = 3'(w_ob_count) + 3'(r_inflight) - 3'(w_pop);
  assign w_issue   = !sys_rst && (w_sram_count != '0) && (w_ob_proj < 3'(OBUF_DEPTH));

  assign mem_rw0_ce   = w_push;
  assign mem_rw0_we   = w_push;
  assign mem_rw0_addr = r_wr_ptr[ADDR_WIDTH-1:0];
  assign mem_rw0_wd   = stream.sink_data;
  assign mem_r0_ce    = w_issue;
  assign mem_r0_addr  = r_rd_ptr[ADDR_WIDTH-1:0];

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_inflight <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_issue) r_rd_ptr <= r_rd_ptr + PW'(1);
      r_inflight <= w_issue;
    end
  end

  liteeth_sram_fifo_obuf #(.BITS(BITS)) u_obuf (
    .i_clk   (sys_clk),
    .i_rst   (sys_rst),
    .i_push  (r_inflight),
    .i_data  (mem_r0_rd),
    .i_pop   (w_pop),
    .o_data  (w_ob_data),
    .o_valid (w_ob_valid),
    .o_count (w_ob_count)
  );

  assign stream.source_valid = w_ob_valid;
  assign stream.source_data  = w_ob_data;
  assign stream.level        = w_sram_count + PW'(r_inflight) + PW'(w_ob_count);

endmodule

// File: tb/tb_liteeth_sram_fifo.sv
// Bench for liteeth_sram_fifo: cycle table for the short sequences, scoreboard
// with an SRAM model for fill, streaming, random traffic and mid-stream reset.
module tb_liteeth_sram_fifo;
  localparam int unsigned BITS  = 12;
  localparam int unsigned DEPTH = 128;
  localparam int unsigned AW    = 7;

  logic          sys_clk = 1'b0;
  logic          sys_rst = 1'b1;
  logic          mem_rw0_ce, mem_rw0_we, mem_r0_ce;
  logic [AW-1:0] mem_rw0_addr, mem_r0_addr;
  logic [BITS-1:0] mem_rw0_wd, mem_r0_rd;
  logic [BITS-1:0] sram [DEPTH];

  liteeth_sram_fifo_if #(.BITS(BITS), .ADDR_WIDTH(AW)) s ();

  liteeth_sram_fifo #(.BITS(BITS), .WORD_DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .stream       (s),
    .mem_rw0_ce   (mem_rw0_ce),
    .mem_rw0_we   (mem_rw0_we),
    .mem_rw0_addr (mem_rw0_addr),
    .mem_rw0_wd   (mem_rw0_wd),
    .mem_r0_ce    (mem_r0_ce),
    .mem_r0_addr  (mem_r0_addr),
    .mem_r0_rd    (mem_r0_rd)
  );

  always #5 sys_clk = ~sys_clk;

  // SRAM model: read data is garbage unless a read was issued the previous cycle.
  always @(posedge sys_clk) begin
    if (mem_rw0_ce && mem_rw0_we) sram[mem_rw0_addr] <= mem_rw0_wd;
    if (mem_r0_ce) mem_r0_rd <= sram[mem_r0_addr];
    else           mem_r0_rd <= BITS'($urandom);
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic tb_sr = 1'b0;
  logic rnd_sr = 1'b0;
  logic rdy_rand = 1'b0;
  assign s.source_ready = rdy_rand ? rnd_sr : tb_sr;
  always @(negedge sys_clk) rnd_sr = 1'($urandom_range(0, 1));

  logic [BITS-1:0] exp_q[$];
  logic sb_en = 1'b0;
  int   cyc = 0, pop_cnt = 0, first_pop = -1, last_pop = -1;
  int   m_wr = 0, m_rd = 0, viol = 0;

  // Monitor samples just before each rising edge, when inputs are settled.
  always begin
    @(negedge sys_clk);
    #4;
    cyc++;
    if (sys_rst) begin
      if (mem_r0_ce || mem_rw0_ce) viol++;
      m_wr = 0;
      m_rd = 0;
    end else begin
      if (mem_rw0_ce && (mem_rw0_we !== 1'b1 || $isunknown(mem_rw0_addr))) viol++;
      if (mem_r0_ce && (m_wr == m_rd || $isunknown(mem_r0_addr))) viol++;
      if (mem_rw0_ce) m_wr++;
      if (mem_r0_ce) m_rd++;
      if (sb_en && s.source_valid && s.source_ready) begin
        if (exp_q.size() == 0) begin
          check("sb_extra_pop", 32'(s.source_data), 32'hFFFF_FFFF);
        end else begin
          check("sb_data", 32'(s.source_data), 32'(exp_q.pop_front()));
        end
        pop_cnt++;
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
      end
    end
  end

  typedef struct {
    logic            sv;
    logic [BITS-1:0] d;
    logic            sr;
    logic            e_rdy;
    logic            e_vld;
    logic [BITS-1:0] e_data;
    logic [AW:0]     e_lvl;
  } vec_t;
  vec_t tbl [19];

  task automatic do_reset();
    @(negedge sys_clk);
    sys_rst = 1'b1;
    s.sink_valid = 1'b1;
    s.sink_data = '0;
    tb_sr = 1'b0;
    #1;
    check("rst_sink_ready", 32'(s.sink_ready), 32'd0);
    check("rst_rw0_ce", 32'(mem_rw0_ce), 32'd0);
    check("rst_r0_ce", 32'(mem_r0_ce), 32'd0);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    s.sink_valid = 1'b0;
    #1;
    check("post_rst_valid", 32'(s.source_valid), 32'd0);
    check("post_rst_level", 32'(s.level), 32'd0);
    check("post_rst_ready", 32'(s.sink_ready), 32'd1);
  endtask

  task automatic push_word(input logic [BITS-1:0] d);
    int w = 0;
    s.sink_valid = 1'b1;
    s.sink_data = d;
    #1;
    while (!s.sink_ready && w < 300) begin
      @(negedge sys_clk);
      #1;
      w++;
    end
    check("push_accept", 32'(s.sink_ready), 32'd1);
    if (s.sink_ready) exp_q.push_back(d);
    @(negedge sys_clk);
    s.sink_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int w = 0;
    tb_sr = 1'b1;
    while ((s.level != '0 || s.source_valid) && w < 4000) begin
      @(negedge sys_clk);
      #1;
      w++;
    end
    check("drain_level", 32'(s.level), 32'd0);
    check("drain_queue_left", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic sb_clear();
    exp_q.delete();
    pop_cnt = 0;
    first_pop = -1;
    last_pop = -1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1;
    s.sink_valid = 1'b0;
    s.sink_data = '0;

    //          sv  data      sr  rdy vld data      level
    tbl[0]  = '{1, 12'hABC, 0,  1,  0,  12'h000, 8'd0};
    tbl[1]  = '{0, 12'h000, 0,  1,  0,  12'h000, 8'd1};
    tbl[2]  = '{0, 12'h000, 0,  1,  0,  12'h000, 8'd1};
    tbl[3]  = '{0, 12'h000, 1,  1,  1,  12'hABC, 8'd1};
    tbl[4]  = '{0, 12'h000, 0,  1,  0,  12'h000, 8'd0};
    tbl[5]  = '{1, 12'h111, 0,  1,  0,  12'h000, 8'd0};
    tbl[6]  = '{1, 12'h222, 0,  1,  0,  12'h000, 8'd1};
    tbl[7]  = '{0, 12'h000, 0,  1,  0,  12'h000, 8'd2};
    tbl[8]  = '{0, 12'h000, 0,  1,  1,  12'h111, 8'd2};
    tbl[9]  = '{0, 12'h000, 1,  1,  1,  12'h111, 8'd2};
    tbl[10] = '{0, 12'h000, 1,  1,  1,  12'h222, 8'd1};
    tbl[11] = '{0, 12'h000, 0,  1,  0,  12'h000, 8'd0};
    tbl[12] = '{1, 12'h333, 0,  1,  0,  12'h000, 8'd0};
    tbl[13] = '{1, 12'h444, 0,  1,  0,  12'h000, 8'd1};
    tbl[14] = '{1, 12'h555, 1,  1,  0,  12'h000, 8'd2};
    tbl[15] = '{0, 12'h000, 1,  1,  1,  12'h333, 8'd3};
    tbl[16] = '{0, 12'h000, 1,  1,  1,  12'h444, 8'd2};
    tbl[17] = '{0, 12'h000, 1,  1,  1,  12'h555, 8'd1};
    tbl[18] = '{0, 12'h000, 0,  1,  0,  12'h000, 8'd0};

    do_reset();
    for (int i = 0; i < 19; i++) begin
      s.sink_valid = tbl[i].sv;
      s.sink_data = tbl[i].d;
      tb_sr = tbl[i].sr;
      #1;
      check($sformatf("vec%0d_sink_ready", i), 32'(s.sink_ready), 32'(tbl[i].e_rdy));
      check($sformatf("vec%0d_valid", i), 32'(s.source_valid), 32'(tbl[i].e_vld));
      if (tbl[i].e_vld) check($sformatf("vec%0d_data", i), 32'(s.source_data), 32'(tbl[i].e_data));
      check($sformatf("vec%0d_level", i), 32'(s.level), 32'(tbl[i].e_lvl));
      @(negedge sys_clk);
    end
    s.sink_valid = 1'b0;
    tb_sr = 1'b0;

    // Fill to capacity: SRAM depth plus the two buffer slots.
    do_reset();
    sb_clear();
    sb_en = 1'b1;
    for (int i = 0; i < 130; i++) push_word(BITS'(i));
    #1;
    check("full_sink_ready", 32'(s.sink_ready), 32'd0);
    check("full_level", 32'(s.level), 32'd130);
    check("full_head", 32'(s.source_data), 32'd0);
    wait_drain();
    check("fill_pop_count", 32'(pop_cnt), 32'd130);

    // Back-to-back streaming across the pointer wrap.
    do_reset();
    sb_clear();
    tb_sr = 1'b1;
    @(negedge sys_clk);
    t0 = cyc;
    for (int i = 0; i < 300; i++) push_word(BITS'(i));
    t1 = cyc;
    check("stream_push_cycles", 32'(t1 - t0), 32'd300);
    wait_drain();
    check("stream_pop_count", 32'(pop_cnt), 32'd300);
    check("stream_pop_span", 32'(last_pop - first_pop), 32'd299);

    // Random valid/ready on both sides.
    do_reset();
    sb_clear();
    rdy_rand = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 1) == 1) @(negedge sys_clk);
      push_word(BITS'($urandom));
    end
    wait_drain();
    rdy_rand = 1'b0;
    check("rand_pop_count", 32'(pop_cnt), 32'd1000);

    // Reset while a read is in flight and the buffer holds data.
    do_reset();
    sb_en = 1'b0;
    sb_clear();
    tb_sr = 1'b0;
    s.sink_valid = 1'b1;
    s.sink_data = 12'h0A1;
    @(negedge sys_clk);
    s.sink_data = 12'h0A2;
    @(negedge sys_clk);
    s.sink_valid = 1'b0;
    @(negedge sys_clk);
    #1;
    check("pre_rst_level", 32'(s.level), 32'd2);
    check("pre_rst_head", 32'(s.source_data), 32'h0A1);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    sys_rst = 1'b0;
    #1;
    check("midrst_valid", 32'(s.source_valid), 32'd0);
    check("midrst_level", 32'(s.level), 32'd0);
    @(negedge sys_clk);
    #1;
    check("midrst_stale_valid", 32'(s.source_valid), 32'd0);
    sb_en = 1'b1;
    tb_sr = 1'b1;
    push_word(12'h123);
    wait_drain();
    repeat (4) @(negedge sys_clk);
    check("midrst_pop_count", 32'(pop_cnt), 32'd1);

    check("protocol_violations", 32'(viol), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
